// File: rtl/top_pipeline.sv
// Five-stage RV32I-subset core (IF/ID/EX/MEM/WB) with on-chip instruction and data memories.
// The program image is written into instruction_memory.Memory before reset is released.
module top_pipeline #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_IMEM = 64,
  parameter int unsigned DEPTH_DMEM = 12
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned IdxHi = $clog2(DEPTH_IMEM) + 1;
  localparam logic [6:0] OpR = 7'h33, OpImm = 7'h13, OpLoad = 7'h03, OpStore = 7'h23;
  localparam logic [6:0] OpBranch = 7'h63, OpLui = 7'h37, OpAuipc = 7'h17;
  localparam logic [6:0] OpJal = 7'h6F, OpJalr = 7'h67;
  localparam logic [3:0] AluAnd = 4'b0000, AluOr = 4'b0001, AluAdd = 4'b0010, AluSltu = 4'b0011;
  localparam logic [3:0] AluSlt = 4'b0100, AluBltu = 4'b0101, AluSub = 4'b0110, AluBgeu = 4'b0111;
  localparam logic [3:0] AluSll = 4'b1000, AluXor = 4'b1001, AluSrl = 4'b1010, AluSra = 4'b1011;
  localparam logic [3:0] AluBeq = 4'b1100, AluBne = 4'b1101, AluBlt = 4'b1110, AluBge = 4'b1111;

  // a_sel: 0 rs1, 1 pc, 2 zero; b_sel: 0 rs2, 1 imm, 2 constant 4
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [3:0] alu;
  } ctrl_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  alu_op = (alt && is_r) ? AluSub : AluAdd;
      3'b001:  alu_op = AluSll;
      3'b010:  alu_op = AluSlt;
      3'b011:  alu_op = AluSltu;
      3'b100:  alu_op = AluXor;
      3'b101:  alu_op = alt ? AluSra : AluSrl;
      3'b110:  alu_op = AluOr;
      default: alu_op = AluAnd;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] flag(input logic c);
    flag = {{(WIDTH - 1){1'b0}}, c};
  endfunction

  logic [WIDTH-1:0] PC_current, PC_next, pc_target, pc_id, pc_ex, jalr_sum;
  logic             PCSrc, stall;
  logic [31:0]      instruction_IF, instruction_ID;
  logic [2:0]       f3_id;
  logic [4:0]       rd_id, rs1_id, rs2_id, rd_ex, rs1_ex, rs2_ex, rd_mem;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [WIDTH-1:0] imm_id, imm_ex, rs1_val_id, rs2_val_id, rs1_val_ex, rs2_val_ex;
  ctrl_t            ctrl_id, ctrl_ex;
  logic [WIDTH-1:0] op1, op2, alu_a, alu_b, ALUResult_EX;
  logic             reg_write_mem, MemRead_MEM, MemWrite_MEM;
  logic [WIDTH-1:0] ALUResult_MEM, WriteData_MEM, MemReadData_MEM;
  logic             RegWrite_WB, mem_read_wb;
  logic [4:0]       Rd_WB;
  logic [WIDTH-1:0] alu_wb, load_wb, WriteData_WB;

  // ---------------- IF ----------------
  if (1) begin : instruction_memory
    logic [31:0] Memory [DEPTH_IMEM] = '{default: 32'h0};
    assign instruction_IF = Memory[PC_current[IdxHi:2]];
  end

  assign PC_next = PCSrc ? pc_target : (stall ? PC_current : PC_current + WIDTH'(4));

  always_ff @(posedge clk) begin
    if (rst) PC_current <= '0;
    else     PC_current <= PC_next;
  end

  always_ff @(posedge clk) begin
    if (rst || PCSrc) begin
      instruction_ID <= '0;
      pc_id          <= '0;
    end else if (!stall) begin
      instruction_ID <= instruction_IF;
      pc_id          <= PC_current;
    end
  end

  // ---------------- ID ----------------
  assign f3_id  = instruction_ID[14:12];
  assign rd_id  = instruction_ID[11:7];
  assign rs1_id = instruction_ID[19:15];
  assign rs2_id = instruction_ID[24:20];
  assign imm_i  = {{20{instruction_ID[31]}}, instruction_ID[31:20]};
  assign imm_s  = {{20{instruction_ID[31]}}, instruction_ID[31:25], instruction_ID[11:7]};
  assign imm_b  = {{19{instruction_ID[31]}}, instruction_ID[31], instruction_ID[7],
                   instruction_ID[30:25], instruction_ID[11:8], 1'b0};
  assign imm_u  = {instruction_ID[31:12], 12'h000};
  assign imm_j  = {{11{instruction_ID[31]}}, instruction_ID[31], instruction_ID[19:12],
                   instruction_ID[20], instruction_ID[30:21], 1'b0};

  always_comb begin
    ctrl_id     = '0;
    ctrl_id.alu = AluAdd;
    imm_id      = '0;
    case (instruction_ID[6:0])
      OpR: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.alu       = alu_op(f3_id, instruction_ID[30], 1'b1);
      end
      OpImm: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.b_sel     = 2'd1;
        ctrl_id.alu       = alu_op(f3_id, instruction_ID[30], 1'b0);
        imm_id            = imm_i;
      end
      OpLoad: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.mem_read  = 1'b1;
        ctrl_id.b_sel     = 2'd1;
        imm_id            = imm_i;
      end
      OpStore: begin
        ctrl_id.mem_write = 1'b1;
        ctrl_id.b_sel     = 2'd1;
        imm_id            = imm_s;
      end
      OpBranch: begin
        imm_id = imm_b;
        // funct3 010/011 are not branches and fall through as NOP
        ctrl_id.branch = (f3_id[2:1] != 2'b01);
        case (f3_id)
          3'b000:  ctrl_id.alu = AluBeq;
          3'b001:  ctrl_id.alu = AluBne;
          3'b100:  ctrl_id.alu = AluBlt;
          3'b101:  ctrl_id.alu = AluBge;
          3'b110:  ctrl_id.alu = AluBltu;
          default: ctrl_id.alu = AluBgeu;
        endcase
      end
      OpLui: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.a_sel     = 2'd2;
        ctrl_id.b_sel     = 2'd1;
        imm_id            = imm_u;
      end
      OpAuipc: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.a_sel     = 2'd1;
        ctrl_id.b_sel     = 2'd1;
        imm_id            = imm_u;
      end
      OpJal, OpJalr: begin
        ctrl_id.reg_write = 1'b1;
        ctrl_id.jal       = (instruction_ID[6:0] == OpJal);
        ctrl_id.jalr      = (instruction_ID[6:0] == OpJalr);
        ctrl_id.a_sel     = 2'd1;
        ctrl_id.b_sel     = 2'd2;
        imm_id            = (instruction_ID[6:0] == OpJal) ? imm_j : imm_i;
      end
      default: ;
    endcase
  end

  if (1) begin : register_file
    logic [WIDTH-1:0] Registers [32];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) Registers[i] <= '0;
      end else if (RegWrite_WB && Rd_WB != 5'd0) begin
        Registers[Rd_WB] <= WriteData_WB;
      end
    end
    // Same-cycle WB write is bypassed to the ID read
    assign rs1_val_id = (rs1_id == 5'd0) ? '0 :
                        (RegWrite_WB && Rd_WB == rs1_id) ? WriteData_WB : Registers[rs1_id];
    assign rs2_val_id = (rs2_id == 5'd0) ? '0 :
                        (RegWrite_WB && Rd_WB == rs2_id) ? WriteData_WB : Registers[rs2_id];
  end

  assign stall = ctrl_ex.mem_read && (rd_ex != 5'd0) && (rd_ex == rs1_id || rd_ex == rs2_id);

  always_ff @(posedge clk) begin
    pc_ex      <= pc_id;
    imm_ex     <= imm_id;
    rs1_val_ex <= rs1_val_id;
    rs2_val_ex <= rs2_val_id;
    rs1_ex     <= rs1_id;
    rs2_ex     <= rs2_id;
    rd_ex      <= rd_id;
    if (rst || PCSrc || stall) ctrl_ex <= '0;
    else                       ctrl_ex <= ctrl_id;
  end

  // ---------------- EX ----------------
  always_comb begin
    op1 = rs1_val_ex;
    op2 = rs2_val_ex;
    if (RegWrite_WB && Rd_WB != 5'd0 && Rd_WB == rs1_ex) op1 = WriteData_WB;
    if (RegWrite_WB && Rd_WB != 5'd0 && Rd_WB == rs2_ex) op2 = WriteData_WB;
    if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs1_ex) op1 = ALUResult_MEM;
    if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs2_ex) op2 = ALUResult_MEM;
  end

  assign alu_a = (ctrl_ex.a_sel == 2'd1) ? pc_ex : (ctrl_ex.a_sel == 2'd2) ? '0 : op1;
  assign alu_b = (ctrl_ex.b_sel == 2'd1) ? imm_ex : (ctrl_ex.b_sel == 2'd2) ? WIDTH'(4) : op2;

  always_comb begin
    ALUResult_EX = '0;
    unique case (ctrl_ex.alu)
      AluAnd:           ALUResult_EX = alu_a & alu_b;
      AluOr:            ALUResult_EX = alu_a | alu_b;
      AluAdd:           ALUResult_EX = alu_a + alu_b;
      AluSltu, AluBltu: ALUResult_EX = flag(alu_a < alu_b);
      AluSlt, AluBlt:   ALUResult_EX = flag($signed(alu_a) < $signed(alu_b));
      AluSub:           ALUResult_EX = alu_a - alu_b;
      AluBgeu:          ALUResult_EX = flag(alu_a >= alu_b);
      AluSll:           ALUResult_EX = alu_a << alu_b[4:0];
      AluXor:           ALUResult_EX = alu_a ^ alu_b;
      AluSrl:           ALUResult_EX = alu_a >> alu_b[4:0];
      AluSra:           ALUResult_EX = $signed(alu_a) >>> alu_b[4:0];
      AluBeq:           ALUResult_EX = flag(alu_a == alu_b);
      AluBne:           ALUResult_EX = flag(alu_a != alu_b);
      AluBge:           ALUResult_EX = flag($signed(alu_a) >= $signed(alu_b));
    endcase
  end

  assign PCSrc     = ctrl_ex.jal || ctrl_ex.jalr || (ctrl_ex.branch && ALUResult_EX[0]);
  assign jalr_sum  = op1 + imm_ex;
  assign pc_target = ctrl_ex.jalr ? {jalr_sum[WIDTH-1:1], 1'b0} : pc_ex + imm_ex;

  always_ff @(posedge clk) begin
    ALUResult_MEM <= ALUResult_EX;
    WriteData_MEM <= op2;
    rd_mem        <= rd_ex;
    if (rst) begin
      reg_write_mem <= 1'b0;
      MemRead_MEM   <= 1'b0;
      MemWrite_MEM  <= 1'b0;
    end else begin
      reg_write_mem <= ctrl_ex.reg_write;
      MemRead_MEM   <= ctrl_ex.mem_read;
      MemWrite_MEM  <= ctrl_ex.mem_write;
    end
  end

  // ---------------- MEM ----------------
  if (1) begin : data_memory
    logic [7:0]            DataMem [2**DEPTH_DMEM] = '{default: 8'h00};
    logic [DEPTH_DMEM-1:0] a0, a1, a2, a3;
    assign a0 = ALUResult_MEM[DEPTH_DMEM-1:0];
    assign a1 = a0 + DEPTH_DMEM'(1);
    assign a2 = a0 + DEPTH_DMEM'(2);
    assign a3 = a0 + DEPTH_DMEM'(3);
    always_ff @(posedge clk) begin
      if (!rst && MemWrite_MEM) begin
        DataMem[a0] <= WriteData_MEM[7:0];
        DataMem[a1] <= WriteData_MEM[15:8];
        DataMem[a2] <= WriteData_MEM[23:16];
        DataMem[a3] <= WriteData_MEM[31:24];
      end
    end
    assign MemReadData_MEM = {DataMem[a3], DataMem[a2], DataMem[a1], DataMem[a0]};
  end

  always_ff @(posedge clk) begin
    Rd_WB   <= rd_mem;
    alu_wb  <= ALUResult_MEM;
    load_wb <= MemReadData_MEM;
    if (rst) begin
      RegWrite_WB <= 1'b0;
      mem_read_wb <= 1'b0;
    end else begin
      RegWrite_WB <= reg_write_mem;
      mem_read_wb <= MemRead_MEM;
    end
  end

  // ---------------- WB ----------------
  assign WriteData_WB = mem_read_wb ? load_wb : alu_wb;

endmodule

// File: tb/tb_top_pipeline.sv
// Directed bench for top_pipeline: preloads small programs and checks architectural state.
module tb_top_pipeline;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  top_pipeline dut (.clk(clk), .rst(rst));

  int n_cmp  = 0;
  int n_fail = 0;
  int pcsrc_count = 0;
  int stall_count = 0;
  logic [31:0] tgt [4];
  logic [31:0] prog [64];

  // Record every redirect target and every cycle the PC holds without a redirect
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.PCSrc) begin
        if (pcsrc_count < 4) tgt[pcsrc_count[1:0]] = dut.PC_next;
        pcsrc_count++;
      end else if (dut.PC_next == dut.PC_current) begin
        stall_count++;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.register_file.Registers[i];
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  task automatic fill_p1();
    clear_prog();
    prog[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);  // addi x1,x0,5
    prog[1] = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'h13);  // addi x2,x0,7
    prog[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);   // add x3,x1,x2
    prog[3] = enc_s(12'd0, 5'd3, 5'd0, 3'b010);         // sw x3,0(x0)
    prog[4] = enc_i(12'd0, 5'd0, 3'b010, 5'd4, 7'h03);  // lw x4,0(x0)
    prog[5] = enc_r(7'h00, 5'd4, 5'd4, 3'b000, 5'd5);   // add x5,x4,x4
  endtask

  task automatic load_and_reset();
    for (int i = 0; i < 64; i++) dut.instruction_memory.Memory[i] = prog[i];
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pcsrc_count = 0;
    stall_count = 0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int nz;
    fill_p1();
    for (int i = 0; i < 64; i++) dut.instruction_memory.Memory[i] = prog[i];
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (rf(i) !== 32'h0) nz++;
    n_cmp++; if (dut.PC_current !== 32'h0) begin n_fail++;
      $display("FAIL reset_pc: got %h want 00000000", dut.PC_current); end
    n_cmp++; if (dut.instruction_ID !== 32'h0) begin n_fail++;
      $display("FAIL reset_instr_id: got %h want 00000000", dut.instruction_ID); end
    n_cmp++; if ({dut.RegWrite_WB, dut.MemRead_MEM, dut.MemWrite_MEM, dut.PCSrc} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000",
        {dut.RegWrite_WB, dut.MemRead_MEM, dut.MemWrite_MEM, dut.PCSrc}); end
    n_cmp++; if (nz !== 0) begin n_fail++;
      $display("FAIL reset_regs: got %0d nonzero want 0", nz); end
    rst = 1'b0;
  endtask

  task automatic test_forward_load_use();
    fill_p1();
    load_and_reset();
    run(4);
    n_cmp++; if (rf(1) !== 32'd0) begin n_fail++;
      $display("FAIL latency_x1_early: got %h want 00000000", rf(1)); end
    run(1);
    n_cmp++; if (rf(1) !== 32'd5) begin n_fail++;
      $display("FAIL latency_x1_cycle5: got %h want 00000005", rf(1)); end
    run(25);
    n_cmp++; if (rf(2) !== 32'd7) begin n_fail++;
      $display("FAIL fwd_x2: got %h want 00000007", rf(2)); end
    n_cmp++; if (rf(3) !== 32'd12) begin n_fail++;
      $display("FAIL fwd_x3: got %h want 0000000c", rf(3)); end
    n_cmp++; if ({dut.data_memory.DataMem[3], dut.data_memory.DataMem[2],
                  dut.data_memory.DataMem[1], dut.data_memory.DataMem[0]} !== 32'h0000000C) begin
      n_fail++; $display("FAIL sw_bytes: got %h %h %h %h want 0c 00 00 00",
        dut.data_memory.DataMem[0], dut.data_memory.DataMem[1],
        dut.data_memory.DataMem[2], dut.data_memory.DataMem[3]); end
    n_cmp++; if (rf(4) !== 32'd12) begin n_fail++;
      $display("FAIL lw_x4: got %h want 0000000c", rf(4)); end
    n_cmp++; if (rf(5) !== 32'd24) begin n_fail++;
      $display("FAIL load_use_x5: got %h want 00000018", rf(5)); end
    n_cmp++; if (stall_count !== 1) begin n_fail++;
      $display("FAIL stall_count: got %0d want 1", stall_count); end
    n_cmp++; if (pcsrc_count !== 0) begin n_fail++;
      $display("FAIL p1_no_redirect: got %0d want 0", pcsrc_count); end
  endtask

  task automatic test_branch();
    clear_prog();
    prog[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'h13);   // addi x1,x0,1
    prog[1] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);          // beq x1,x1,+8
    prog[2] = enc_i(12'd99, 5'd0, 3'b000, 5'd6, 7'h13);  // addi x6,x0,99
    prog[3] = enc_i(12'd3, 5'd0, 3'b000, 5'd7, 7'h13);   // addi x7,x0,3
    prog[4] = enc_b(13'd8, 5'd1, 5'd1, 3'b001);          // bne x1,x1,+8 (not taken)
    prog[5] = enc_i(12'd4, 5'd0, 3'b000, 5'd12, 7'h13);  // addi x12,x0,4
    load_and_reset();
    run(25);
    n_cmp++; if (pcsrc_count !== 1) begin n_fail++;
      $display("FAIL branch_pulses: got %0d want 1", pcsrc_count); end
    n_cmp++; if (tgt[0] !== 32'h0C) begin n_fail++;
      $display("FAIL branch_target: got %h want 0000000c", tgt[0]); end
    n_cmp++; if (rf(6) !== 32'd0) begin n_fail++;
      $display("FAIL branch_shadow_x6: got %h want 00000000", rf(6)); end
    n_cmp++; if (rf(7) !== 32'd3) begin n_fail++;
      $display("FAIL branch_x7: got %h want 00000003", rf(7)); end
    n_cmp++; if (rf(12) !== 32'd4) begin n_fail++;
      $display("FAIL bne_fallthrough_x12: got %h want 00000004", rf(12)); end
  endtask

  task automatic test_jumps();
    clear_prog();
    prog[4] = enc_j(21'd8, 5'd8);                         // 10: jal x8,+8
    prog[5] = enc_i(12'd42, 5'd0, 3'b000, 5'd13, 7'h13);  // 14: addi x13,x0,42
    prog[6] = enc_b(13'd12, 5'd0, 5'd9, 3'b001);          // 18: bne x9,x0,+12
    prog[7] = enc_i(12'd0, 5'd8, 3'b000, 5'd9, 7'h67);    // 1C: jalr x9,0(x8)
    prog[8] = enc_i(12'd1, 5'd0, 3'b000, 5'd14, 7'h13);   // 20: addi x14,x0,1
    prog[9] = enc_i(12'd7, 5'd0, 3'b000, 5'd15, 7'h13);   // 24: addi x15,x0,7
    load_and_reset();
    run(40);
    n_cmp++; if (rf(8) !== 32'h14) begin n_fail++;
      $display("FAIL jal_link_x8: got %h want 00000014", rf(8)); end
    n_cmp++; if (tgt[0] !== 32'h18) begin n_fail++;
      $display("FAIL jal_target: got %h want 00000018", tgt[0]); end
    n_cmp++; if (tgt[1] !== 32'h14) begin n_fail++;
      $display("FAIL jalr_target: got %h want 00000014", tgt[1]); end
    n_cmp++; if (rf(9) !== 32'h20) begin n_fail++;
      $display("FAIL jalr_link_x9: got %h want 00000020", rf(9)); end
    n_cmp++; if ({rf(13), rf(14), rf(15)} !== {32'd42, 32'd0, 32'd7}) begin n_fail++;
      $display("FAIL jump_flow: got x13=%h x14=%h x15=%h want 2a 0 7", rf(13), rf(14), rf(15));
    end
    n_cmp++; if (pcsrc_count !== 3 || tgt[2] !== 32'h24) begin n_fail++;
      $display("FAIL jump_redirects: got %0d/%h want 3/00000024", pcsrc_count, tgt[2]); end
  endtask

  task automatic test_upper_alu();
    clear_prog();
    prog[0]  = enc_u(20'h12345, 5'd10, 7'h37);                // lui x10,0x12345
    prog[1]  = enc_u(20'h0, 5'd11, 7'h17);                    // auipc x11,0
    prog[2]  = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'h13);       // addi x0,x0,5
    prog[3]  = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd16);       // add x16,x0,x0
    prog[4]  = enc_u(20'h1, 5'd17, 7'h17);                    // auipc x17,1
    prog[5]  = enc_i(12'hFF8, 5'd0, 3'b000, 5'd18, 7'h13);    // addi x18,x0,-8
    prog[6]  = enc_i(12'h401, 5'd18, 3'b101, 5'd19, 7'h13);   // srai x19,x18,1
    prog[7]  = enc_r(7'h00, 5'd18, 5'd0, 3'b011, 5'd20);      // sltu x20,x0,x18
    prog[8]  = enc_r(7'h00, 5'd0, 5'd18, 3'b010, 5'd21);      // slt x21,x18,x0
    prog[9]  = enc_r(7'h20, 5'd18, 5'd0, 3'b000, 5'd22);      // sub x22,x0,x18
    prog[10] = enc_i(12'd28, 5'd18, 3'b101, 5'd23, 7'h13);    // srli x23,x18,28
    load_and_reset();
    run(25);
    n_cmp++; if (rf(10) !== 32'h12345000) begin n_fail++;
      $display("FAIL lui_x10: got %h want 12345000", rf(10)); end
    n_cmp++; if (rf(11) !== 32'h4) begin n_fail++;
      $display("FAIL auipc_x11: got %h want 00000004", rf(11)); end
    n_cmp++; if (rf(0) !== 32'h0 || rf(16) !== 32'h0) begin n_fail++;
      $display("FAIL x0_write: got x0=%h x16=%h want 0 0", rf(0), rf(16)); end
    n_cmp++; if (rf(17) !== 32'h1010) begin n_fail++;
      $display("FAIL auipc_x17: got %h want 00001010", rf(17)); end
    n_cmp++; if (rf(19) !== 32'hFFFFFFFC) begin n_fail++;
      $display("FAIL srai_x19: got %h want fffffffc", rf(19)); end
    n_cmp++; if ({rf(20), rf(21)} !== {32'd1, 32'd1}) begin n_fail++;
      $display("FAIL slt_sltu: got %h %h want 1 1", rf(20), rf(21)); end
    n_cmp++; if (rf(22) !== 32'd8 || rf(23) !== 32'hF) begin n_fail++;
      $display("FAIL sub_srli: got %h %h want 8 f", rf(22), rf(23)); end
  endtask

  task automatic test_reset_midrun();
    int nz;
    fill_p1();
    load_and_reset();
    run(7);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (rf(i) !== 32'h0) nz++;
    n_cmp++; if (dut.PC_current !== 32'h0 || dut.instruction_ID !== 32'h0) begin n_fail++;
      $display("FAIL midrun_pc_id: got %h %h want 0 0", dut.PC_current, dut.instruction_ID); end
    n_cmp++; if (nz !== 0 || dut.RegWrite_WB !== 1'b0) begin n_fail++;
      $display("FAIL midrun_regs: got %0d nonzero wb=%b want 0 0", nz, dut.RegWrite_WB); end
    rst = 1'b0;
    pcsrc_count = 0;
    stall_count = 0;
    run(30);
    n_cmp++; if ({rf(3), rf(4), rf(5)} !== {32'd12, 32'd12, 32'd24}) begin n_fail++;
      $display("FAIL midrun_rerun: got %h %h %h want c c 18", rf(3), rf(4), rf(5)); end
    n_cmp++; if (stall_count !== 1) begin n_fail++;
      $display("FAIL midrun_stalls: got %0d want 1", stall_count); end
  endtask

  initial begin
    test_reset();
    test_forward_load_use();
    test_branch();
    test_jumps();
    test_upper_alu();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
